// File: rtl/axi4lite_mem_master.sv
// AXI4-lite bus master for core loads/stores: splits 1/2/4/8-byte accesses at any alignment
// into one or two aligned 64-bit beats and returns a single merged completion.
module axi4lite_mem_master #(
   parameter int                ADDR_W    = 64,
   parameter logic [ADDR_W-1:0] ADDR_MASK = {ADDR_W{1'b1}}
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_req_valid,
   output logic              o_req_ready,
   input  logic              i_req_write,
   input  logic [ADDR_W-1:0] i_req_addr,
   input  logic [1:0]        i_req_size,
   input  logic [63:0]       i_req_wdata,
   output logic              o_resp_valid,
   output logic [63:0]       o_resp_rdata,
   output logic              o_resp_err,
   output logic [ADDR_W-1:0] o_m_araddr,
   output logic              o_m_arvalid,
   input  logic              i_m_arready,
   input  logic [63:0]       i_m_rdata,
   input  logic [1:0]        i_m_rresp,
   input  logic              i_m_rvalid,
   output logic              o_m_rready,
   output logic [ADDR_W-1:0] o_m_awaddr,
   output logic              o_m_awvalid,
   input  logic              i_m_awready,
   output logic [63:0]       o_m_wdata,
   output logic [7:0]        o_m_wstrb,
   output logic              o_m_wvalid,
   input  logic              i_m_wready,
   input  logic [1:0]        i_m_bresp,
   input  logic              i_m_bvalid,
   output logic              o_m_bready
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_ADDR = 2'd1,
      S_DATA = 2'd2,
      S_DONE = 2'd3
   } state_t;

   function automatic logic [63:0] f_size_mask(input logic [1:0] sz);
      logic [63:0] m;
      case (sz)
         2'd0:    m = 64'h0000_0000_0000_00FF;
         2'd1:    m = 64'h0000_0000_0000_FFFF;
         2'd2:    m = 64'h0000_0000_FFFF_FFFF;
         default: m = 64'hFFFF_FFFF_FFFF_FFFF;
      endcase
      return m;
   endfunction

   function automatic logic [7:0] f_byte_mask(input logic [1:0] sz);
      logic [7:0] m;
      case (sz)
         2'd0:    m = 8'h01;
         2'd1:    m = 8'h03;
         2'd2:    m = 8'h0F;
         default: m = 8'hFF;
      endcase
      return m;
   endfunction

   state_t            r_state;
   state_t            w_state_nx;
   logic              r_req_ready, r_resp_valid, r_resp_err, r_rready, r_bready;
   logic [63:0]       r_resp_rdata;
   logic              r_write, r_split, r_beat;
   logic [2:0]        r_off;
   logic [1:0]        r_size;
   logic [ADDR_W-1:0] r_axaddr, r_addr1;
   logic [63:0]       r_wdata, r_whi, r_r0;
   logic [7:0]        r_wstrb, r_strb_hi;
   logic              r_awvalid, r_wvalid, r_arvalid;

   logic              w_accept, w_next_beat, w_finish, w_beat_err;
   logic              w_aw_fin, w_w_fin, w_resp_hs;
   logic [1:0]        w_resp;
   logic [2:0]        w_off;
   logic [3:0]        w_nbytes;
   logic              w_split;
   logic [ADDR_W-1:0] w_base, w_addr0, w_addr1;
   logic [127:0]      w_wide, w_data128;
   logic [15:0]       w_strb16;
   logic [63:0]       w_rshift, w_rmerged;

   // Request decode: beat addresses, shifted store data and byte strobes.
   assign w_off     = i_req_addr[2:0];
   assign w_nbytes  = 4'd1 << i_req_size;
   assign w_split   = ({1'b0, w_off} + w_nbytes) > 4'd8;
   assign w_base    = {i_req_addr[ADDR_W-1:3], 3'b000};
   assign w_addr0   = w_base & ADDR_MASK;
   assign w_addr1   = (w_base + {{(ADDR_W-4){1'b0}}, 4'd8}) & ADDR_MASK;
   assign w_wide    = {64'd0, i_req_wdata & f_size_mask(i_req_size)} << {w_off, 3'b000};
   assign w_strb16  = {8'd0, f_byte_mask(i_req_size)} << w_off;

   // Load merge: the beat-1 word sits above beat 0, then realign to the requested byte.
   assign w_data128 = r_split ? {i_m_rdata, r_r0} : {64'd0, i_m_rdata};
   assign w_rshift  = 64'(w_data128 >> {r_off, 3'b000});
   assign w_rmerged = w_rshift & f_size_mask(r_size);

   assign w_aw_fin  = !r_awvalid || i_m_awready;
   assign w_w_fin   = !r_wvalid || i_m_wready;
   assign w_resp_hs = r_write ? i_m_bvalid : i_m_rvalid;
   assign w_resp    = r_write ? i_m_bresp : i_m_rresp;

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nx;
      end
   end

   // Next-state logic and per-cycle control strobes.
   always_comb begin
      w_state_nx  = r_state;
      w_accept    = 1'b0;
      w_next_beat = 1'b0;
      w_finish    = 1'b0;
      w_beat_err  = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (i_req_valid) begin
               w_accept   = 1'b1;
               w_state_nx = S_ADDR;
            end else begin
               w_state_nx = S_IDLE;
            end
         end
         S_ADDR: begin
            if (r_write) begin
               w_state_nx = (w_aw_fin && w_w_fin) ? S_DATA : S_ADDR;
            end else begin
               w_state_nx = i_m_arready ? S_DATA : S_ADDR;
            end
         end
         S_DATA: begin
            if (w_resp_hs) begin
               w_beat_err = (w_resp != 2'b00);
               // A failed first beat ends the access without touching the second word.
               if (r_split && !r_beat && !w_beat_err) begin
                  w_next_beat = 1'b1;
                  w_state_nx  = S_ADDR;
               end else begin
                  w_finish   = 1'b1;
                  w_state_nx = S_DONE;
               end
            end else begin
               w_state_nx = S_DATA;
            end
         end
         S_DONE:  w_state_nx = S_IDLE;
         default: w_state_nx = S_IDLE;
      endcase
   end

   // Datapath, AXI valids/readies and completion registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_req_ready  <= 1'b1;
         r_resp_valid <= 1'b0;
         r_resp_err   <= 1'b0;
         r_resp_rdata <= 64'd0;
         r_rready     <= 1'b0;
         r_bready     <= 1'b0;
         r_write      <= 1'b0;
         r_split      <= 1'b0;
         r_beat       <= 1'b0;
         r_off        <= 3'd0;
         r_size       <= 2'd0;
         r_axaddr     <= {ADDR_W{1'b0}};
         r_addr1      <= {ADDR_W{1'b0}};
         r_wdata      <= 64'd0;
         r_whi        <= 64'd0;
         r_r0         <= 64'd0;
         r_wstrb      <= 8'd0;
         r_strb_hi    <= 8'd0;
         r_awvalid    <= 1'b0;
         r_wvalid     <= 1'b0;
         r_arvalid    <= 1'b0;
      end else begin
         r_req_ready  <= (w_state_nx == S_IDLE);
         r_rready     <= (w_state_nx == S_DATA) && !r_write;
         r_bready     <= (w_state_nx == S_DATA) && r_write;
         r_resp_valid <= w_finish;
         if (w_accept) begin
            r_write   <= i_req_write;
            r_split   <= w_split;
            r_beat    <= 1'b0;
            r_off     <= w_off;
            r_size    <= i_req_size;
            r_axaddr  <= w_addr0;
            r_addr1   <= w_addr1;
            r_wdata   <= w_wide[63:0];
            r_whi     <= w_wide[127:64];
            r_wstrb   <= w_strb16[7:0];
            r_strb_hi <= w_strb16[15:8];
            r_awvalid <= i_req_write;
            r_wvalid  <= i_req_write;
            r_arvalid <= !i_req_write;
         end else if (w_next_beat) begin
            r_beat    <= 1'b1;
            r_r0      <= i_m_rdata;
            r_axaddr  <= r_addr1;
            r_wdata   <= r_whi;
            r_wstrb   <= r_strb_hi;
            r_awvalid <= r_write;
            r_wvalid  <= r_write;
            r_arvalid <= !r_write;
         end else begin
            r_awvalid <= r_awvalid && !i_m_awready;
            r_wvalid  <= r_wvalid && !i_m_wready;
            r_arvalid <= r_arvalid && !i_m_arready;
         end
         if (w_finish) begin
            r_resp_err <= w_beat_err;
            if (!r_write) begin
               r_resp_rdata <= w_rmerged;
            end
         end
      end
   end

   assign o_req_ready  = r_req_ready;
   assign o_resp_valid = r_resp_valid;
   assign o_resp_rdata = r_resp_rdata;
   assign o_resp_err   = r_resp_err;
   assign o_m_araddr   = r_axaddr;
   assign o_m_arvalid  = r_arvalid;
   assign o_m_rready   = r_rready;
   assign o_m_awaddr   = r_axaddr;
   assign o_m_awvalid  = r_awvalid;
   assign o_m_wdata    = r_wdata;
   assign o_m_wstrb    = r_wstrb;
   assign o_m_wvalid   = r_wvalid;
   assign o_m_bready   = r_bready;

endmodule

// File: tb/tb_axi4lite_mem_master.sv
// Directed bench for axi4lite_mem_master: table of loads/stores against a small AXI4-lite
// slave model, plus hand sequences for error-abort, AW back-pressure and mid-transaction reset.
module tb_axi4lite_mem_master;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        req_valid = 1'b0, req_write = 1'b0;
   logic        req_ready;
   logic [63:0] req_addr = 64'd0, req_wdata = 64'd0;
   logic [1:0]  req_size = 2'd0;
   logic        resp_valid, resp_err;
   logic [63:0] resp_rdata;
   logic [63:0] m_araddr, m_awaddr, m_wdata;
   logic        m_arvalid, m_rready, m_awvalid, m_wvalid, m_bready;
   logic [7:0]  m_wstrb;
   logic        m_arready = 1'b0, m_awready = 1'b0, m_wready = 1'b0;
   logic        m_rvalid = 1'b0, m_bvalid = 1'b0;
   logic [63:0] m_rdata = 64'd0;
   logic [1:0]  m_rresp = 2'b00, m_bresp = 2'b00;

   axi4lite_mem_master dut (
      .clk(clk), .rst(rst),
      .i_req_valid(req_valid), .o_req_ready(req_ready), .i_req_write(req_write),
      .i_req_addr(req_addr), .i_req_size(req_size), .i_req_wdata(req_wdata),
      .o_resp_valid(resp_valid), .o_resp_rdata(resp_rdata), .o_resp_err(resp_err),
      .o_m_araddr(m_araddr), .o_m_arvalid(m_arvalid), .i_m_arready(m_arready),
      .i_m_rdata(m_rdata), .i_m_rresp(m_rresp), .i_m_rvalid(m_rvalid), .o_m_rready(m_rready),
      .o_m_awaddr(m_awaddr), .o_m_awvalid(m_awvalid), .i_m_awready(m_awready),
      .o_m_wdata(m_wdata), .o_m_wstrb(m_wstrb), .o_m_wvalid(m_wvalid), .i_m_wready(m_wready),
      .i_m_bresp(m_bresp), .i_m_bvalid(m_bvalid), .o_m_bready(m_bready)
   );

   always #5 clk = ~clk;

   // Slave model state: memory word index is addr[7:3]
   logic [63:0] mem [0:31];
   int          aw_stall = 0, ar_stall = 0;
   bit          err_next_b = 1'b0;
   bit          got_aw = 1'b0, got_w = 1'b0, ar_pend = 1'b0, hs_b = 1'b0, hs_r = 1'b0;
   logic [63:0] pend_awaddr, pend_wdata, pend_araddr;
   logic [7:0]  pend_wstrb;
   logic [63:0] aw_log[$], ar_log[$], wd_log[$];
   logic [7:0]  ws_log[$];
   int          resp_cnt = 0, overlap_cnt = 0;
   int          n_cmp = 0, n_fail = 0;

   // Slave runs on the falling edge: retire last edge's handshakes, respond, then set readies.
   always @(negedge clk) begin
      if (rst) begin
         m_bvalid = 1'b0; m_rvalid = 1'b0; got_aw = 1'b0; got_w = 1'b0; ar_pend = 1'b0;
         hs_b = 1'b0; hs_r = 1'b0; m_awready = 1'b0; m_wready = 1'b0; m_arready = 1'b0;
      end else begin
         if (hs_b) m_bvalid = 1'b0;
         if (hs_r) m_rvalid = 1'b0;
         if (got_aw && got_w && !m_bvalid) begin
            for (int b = 0; b < 8; b++)
               if (pend_wstrb[b]) mem[pend_awaddr[7:3]][8*b +: 8] = pend_wdata[8*b +: 8];
            m_bresp = err_next_b ? 2'b10 : 2'b00;
            err_next_b = 1'b0;
            m_bvalid = 1'b1; got_aw = 1'b0; got_w = 1'b0;
         end
         if (ar_pend && !m_rvalid) begin
            m_rdata = mem[pend_araddr[7:3]]; m_rresp = 2'b00; m_rvalid = 1'b1; ar_pend = 1'b0;
         end
         if (m_awvalid && aw_stall > 0) begin m_awready = 1'b0; aw_stall--; end
         else m_awready = 1'b1;
         if (m_arvalid && ar_stall > 0) begin m_arready = 1'b0; ar_stall--; end
         else m_arready = 1'b1;
         m_wready = 1'b1;
         if (m_awvalid && m_awready) begin got_aw = 1'b1; pend_awaddr = m_awaddr; aw_log.push_back(m_awaddr); end
         if (m_wvalid && m_wready) begin
            got_w = 1'b1; pend_wdata = m_wdata; pend_wstrb = m_wstrb;
            wd_log.push_back(m_wdata); ws_log.push_back(m_wstrb);
         end
         if (m_arvalid && m_arready) begin ar_pend = 1'b1; pend_araddr = m_araddr; ar_log.push_back(m_araddr); end
         hs_b = m_bvalid && m_bready;
         hs_r = m_rvalid && m_rready;
         if (m_awvalid && m_arvalid) overlap_cnt++;
         if (resp_valid) resp_cnt++;
      end
   end

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp_v);
      n_cmp++;
      if (act !== exp_v) begin
         n_fail++;
         $display("FAIL %s: actual=%h required=%h", nm, act, exp_v);
      end
   endtask

   task automatic start_req(input logic wr, input logic [63:0] addr, input logic [1:0] sz,
                            input logic [63:0] wd);
      int t;
      t = 0;
      @(negedge clk);
      while (!req_ready && t < 50) begin @(negedge clk); t++; end
      chk("req_ready_wait", {63'd0, req_ready}, 64'd1);
      req_valid = 1'b1; req_write = wr; req_addr = addr; req_size = sz; req_wdata = wd;
      @(negedge clk);
      req_valid = 1'b0; req_addr = 64'hDEAD_BEEF_DEAD_BEE7; req_wdata = 64'hA5A5_A5A5_A5A5_A5A5;
   endtask

   // Called at a falling edge; 'lat' counts cycles since acceptance.
   task automatic wait_resp(input int start, output int lat, output logic ok);
      lat = start;
      while (!resp_valid && lat < 60) begin @(negedge clk); lat++; end
      ok = resp_valid;
   endtask

   typedef struct {
      logic        wr;
      logic [63:0] addr;
      logic [1:0]  size;
      logic [63:0] wdata;
      logic [63:0] exp_rdata;
      int          exp_beats;
      logic [63:0] exp_a0, exp_a1;
      logic [7:0]  exp_s0, exp_s1;
      logic [63:0] exp_w0, exp_w1;
      int          exp_lat;
   } vec_t;

   localparam int NV = 12;
   vec_t        vecs [NV];
   vec_t        v;
   int          lat, pre, nb;
   logic        ok;
   logic [63:0] a0, a1, w0, w1, got_rd;
   logic [7:0]  s0, s1;
   logic        got_err;

   initial begin
      for (int i = 0; i < 32; i++) mem[i] = 64'd0;
      mem[0]  = 64'h0000_0000_0000_00AA;
      mem[1]  = 64'h0706_0504_0302_0100;
      mem[2]  = 64'h0F0E_0D0C_0B0A_0908;
      mem[31] = 64'h8877_6655_4433_2211;

      // Byte k of the slave word at 0x08 is 0x0k, byte k at 0x10 is 0x08+k.
      vecs[0]  = '{1'b0, 64'h0B, 2'd3, 64'd0, 64'h0A09_0807_0605_0403, 2, 64'h08, 64'h10, 8'h00, 8'h00, 64'd0, 64'd0, 5};
      vecs[1]  = '{1'b0, 64'h0D, 2'd0, 64'd0, 64'h0000_0000_0000_0005, 1, 64'h08, 64'h00, 8'h00, 8'h00, 64'd0, 64'd0, 3};
      vecs[2]  = '{1'b0, 64'h0F, 2'd3, 64'd0, 64'h0E0D_0C0B_0A09_0807, 2, 64'h08, 64'h10, 8'h00, 8'h00, 64'd0, 64'd0, 5};
      vecs[3]  = '{1'b0, 64'h0A, 2'd1, 64'd0, 64'h0000_0000_0000_0302, 1, 64'h08, 64'h00, 8'h00, 8'h00, 64'd0, 64'd0, 3};
      vecs[4]  = '{1'b0, 64'h0C, 2'd2, 64'd0, 64'h0000_0000_0706_0504, 1, 64'h08, 64'h00, 8'h00, 8'h00, 64'd0, 64'd0, 3};
      vecs[5]  = '{1'b0, 64'h0E, 2'd2, 64'd0, 64'h0000_0000_0908_0706, 2, 64'h08, 64'h10, 8'h00, 8'h00, 64'd0, 64'd0, 5};
      vecs[6]  = '{1'b1, 64'h10, 2'd3, 64'h1122_3344_5566_7788, 64'h0000_0000_0908_0706, 1, 64'h10, 64'h00,
                   8'hFF, 8'h00, 64'h1122_3344_5566_7788, 64'd0, 3};
      vecs[7]  = '{1'b1, 64'h0E, 2'd2, 64'h0000_0000_AABB_CCDD, 64'h0000_0000_0908_0706, 2, 64'h08, 64'h10,
                   8'hC0, 8'h03, 64'hCCDD_0000_0000_0000, 64'h0000_0000_0000_AABB, 5};
      vecs[8]  = '{1'b1, 64'h13, 2'd0, 64'hFFFF_FFFF_FFFF_FF5A, 64'h0000_0000_0908_0706, 1, 64'h10, 64'h00,
                   8'h08, 8'h00, 64'h0000_0000_5A00_0000, 64'd0, 3};
      vecs[9]  = '{1'b0, 64'h10, 2'd3, 64'd0, 64'h1122_3344_5A66_AABB, 1, 64'h10, 64'h00, 8'h00, 8'h00, 64'd0, 64'd0, 3};
      vecs[10] = '{1'b1, 64'h0F, 2'd1, 64'h0000_0000_0000_BEEF, 64'h1122_3344_5A66_AABB, 2, 64'h08, 64'h10,
                   8'h80, 8'h01, 64'hEF00_0000_0000_0000, 64'h0000_0000_0000_00BE, 5};
      vecs[11] = '{1'b0, 64'hFFFF_FFFF_FFFF_FFFC, 2'd3, 64'd0, 64'h0000_00AA_8877_6655, 2,
                   64'hFFFF_FFFF_FFFF_FFF8, 64'h0000_0000_0000_0000, 8'h00, 8'h00, 64'd0, 64'd0, 5};

      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("rst_req_ready", {63'd0, req_ready}, 64'd1);
      chk("rst_resp_valid", {63'd0, resp_valid}, 64'd0);
      chk("rst_resp_err", {63'd0, resp_err}, 64'd0);
      chk("rst_resp_rdata", resp_rdata, 64'd0);
      chk("rst_valids", {59'd0, m_arvalid, m_awvalid, m_wvalid, m_rready, m_bready}, 64'd0);

      for (int i = 0; i < NV; i++) begin
         v = vecs[i];
         aw_log.delete(); ar_log.delete(); wd_log.delete(); ws_log.delete();
         pre = resp_cnt;
         start_req(v.wr, v.addr, v.size, v.wdata);
         wait_resp(1, lat, ok);
         chk($sformatf("v%0d_done", i), {63'd0, ok}, 64'd1);
         got_rd = resp_rdata; got_err = resp_err;
         chk($sformatf("v%0d_rdata", i), got_rd, v.exp_rdata);
         chk($sformatf("v%0d_err", i), {63'd0, got_err}, 64'd0);
         chk($sformatf("v%0d_latency", i), 64'(lat), 64'(v.exp_lat));
         @(negedge clk);
         chk($sformatf("v%0d_pulse_width", i), {63'd0, resp_valid}, 64'd0);
         @(negedge clk);
         chk($sformatf("v%0d_resp_count", i), 64'(resp_cnt - pre), 64'd1);
         nb = v.wr ? aw_log.size() : ar_log.size();
         chk($sformatf("v%0d_beats", i), 64'(nb), 64'(v.exp_beats));
         a0 = 'x; a1 = 'x; w0 = 'x; w1 = 'x; s0 = 'x; s1 = 'x;
         if (v.wr) begin
            if (aw_log.size() > 0) a0 = aw_log[0];
            if (aw_log.size() > 1) a1 = aw_log[1];
            if (wd_log.size() > 0) begin w0 = wd_log[0]; s0 = ws_log[0]; end
            if (wd_log.size() > 1) begin w1 = wd_log[1]; s1 = ws_log[1]; end
         end else begin
            if (ar_log.size() > 0) a0 = ar_log[0];
            if (ar_log.size() > 1) a1 = ar_log[1];
         end
         chk($sformatf("v%0d_addr0", i), a0, v.exp_a0);
         if (v.exp_beats == 2) chk($sformatf("v%0d_addr1", i), a1, v.exp_a1);
         if (v.wr) begin
            chk($sformatf("v%0d_wbeats", i), 64'(wd_log.size()), 64'(v.exp_beats));
            chk($sformatf("v%0d_wstrb0", i), {56'd0, s0}, {56'd0, v.exp_s0});
            chk($sformatf("v%0d_wdata0", i), w0, v.exp_w0);
            if (v.exp_beats == 2) begin
               chk($sformatf("v%0d_wstrb1", i), {56'd0, s1}, {56'd0, v.exp_s1});
               chk($sformatf("v%0d_wdata1", i), w1, v.exp_w1);
            end
         end
      end

      // Split store whose first beat gets SLVERR: second beat must not be issued.
      aw_log.delete(); wd_log.delete(); ws_log.delete();
      err_next_b = 1'b1;
      pre = resp_cnt;
      start_req(1'b1, 64'h0C, 2'd3, 64'h0123_4567_89AB_CDEF);
      wait_resp(1, lat, ok);
      chk("err_done", {63'd0, ok}, 64'd1);
      chk("err_resp_err", {63'd0, resp_err}, 64'd1);
      chk("err_rdata_held", resp_rdata, 64'h0000_00AA_8877_6655);
      chk("err_latency", 64'(lat), 64'd3);
      repeat (6) @(negedge clk);
      chk("err_aw_count", 64'(aw_log.size()), 64'd1);
      chk("err_aw_addr", aw_log.size() > 0 ? aw_log[0] : 64'hX, 64'h08);
      chk("err_resp_count", 64'(resp_cnt - pre), 64'd1);

      // AW held off for three cycles while W is accepted immediately.
      aw_log.delete(); wd_log.delete(); ws_log.delete();
      aw_stall = 3;
      pre = resp_cnt;
      start_req(1'b1, 64'h20, 2'd3, 64'hCAFE_F00D_1234_5678);
      chk("stall_c1_awvalid", {63'd0, m_awvalid}, 64'd1);
      chk("stall_c1_wvalid", {63'd0, m_wvalid}, 64'd1);
      @(negedge clk);
      chk("stall_c2_wvalid", {63'd0, m_wvalid}, 64'd0);
      chk("stall_c2_awvalid", {63'd0, m_awvalid}, 64'd1);
      chk("stall_c2_awaddr", m_awaddr, 64'h20);
      @(negedge clk);
      chk("stall_c3_awvalid", {63'd0, m_awvalid}, 64'd1);
      chk("stall_c3_awaddr", m_awaddr, 64'h20);
      wait_resp(3, lat, ok);
      chk("stall_done", {63'd0, ok}, 64'd1);
      chk("stall_latency", 64'(lat), 64'd6);
      chk("stall_resp_err", {63'd0, resp_err}, 64'd0);
      repeat (3) @(negedge clk);
      chk("stall_aw_count", 64'(aw_log.size()), 64'd1);
      chk("stall_w_count", 64'(wd_log.size()), 64'd1);
      chk("stall_resp_count", 64'(resp_cnt - pre), 64'd1);
      chk("stall_mem", mem[4], 64'hCAFE_F00D_1234_5678);

      // Reset while a read address is waiting for arready.
      ar_stall = 1000;
      pre = resp_cnt;
      start_req(1'b0, 64'h08, 2'd3, 64'd0);
      @(negedge clk);
      chk("rstmid_arvalid_before", {63'd0, m_arvalid}, 64'd1);
      rst = 1'b1;
      @(negedge clk);
      chk("rstmid_arvalid_after", {63'd0, m_arvalid}, 64'd0);
      chk("rstmid_req_ready", {63'd0, req_ready}, 64'd1);
      chk("rstmid_resp_rdata", resp_rdata, 64'd0);
      rst = 1'b0;
      ar_stall = 0;
      repeat (6) @(negedge clk);
      chk("rstmid_no_resp", 64'(resp_cnt - pre), 64'd0);
      chk("rstmid_idle", {62'd0, req_ready, m_arvalid}, 64'd2);

      chk("no_ar_aw_overlap", 64'(overlap_cnt), 64'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
